dmem_mmio: RTL and testbench
============================

# dmem_mmio

Data-side memory responder for the single-cycle ARM core: it answers the core's MemWrite/ALUResult/WriteData/ReadData port. It holds a word-addressed data RAM and a small MMIO page containing a cycle counter, a compare/interrupt register and a byte transmit FIFO. The FIFO drains to an external console over a valid/ready handshake. Reads are combinational, so a load completes in the same cycle. Writes commit on the rising clock edge.

## Interface
- RAM_WORDS, 64, number of 32-bit RAM words; power of 2
- FIFO_DEPTH, 4, TX FIFO entries; power of 2, 2..8
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- MemWrite  input  1  write strobe from the core
- ALUResult  input  32  byte address from the core
- WriteData  input  32  store data
- ReadData  output  32  load data, combinational from ALUResult and current state
- tx_data  output  8  FIFO head byte
- tx_valid  output  1  FIFO non-empty
- tx_ready  input  1  console accepts the head byte
- irq  output  1  compare-match interrupt pending

## Operation
- Address decode ignores ALUResult[1:0]; all accesses are whole words.
- RAM is 0x0000_0000 to RAM_WORDS*4-1, indexed by ALUResult[log2(RAM_WORDS)+1:2].
  - Upper bits must be zero to hit RAM.
  - RAM is not cleared by reset.
- CYCLE, 0xFFFF_FF00, read/write.
  - Free-running 32-bit counter; +1 every cycle; wraps 0xFFFF_FFFF→0.
  - A write loads WriteData; counting resumes from that value on the next cycle.
- CMP, 0xFFFF_FF04, read/write; reset value 0xFFFF_FFFF.
- STATUS, 0xFFFF_FF08.
  - Read layout: bit0 fifo_empty, bit1 fifo_full, bit2 irq_pending, bit3 overflow, bits[7:4] fifo count, others 0.
  - Write is write-1-to-clear: bit2 clears irq_pending, bit3 clears overflow; other bits are ignored.
- TXDATA, 0xFFFF_FF0C.
  - Write pushes WriteData[7:0] into the FIFO.
  - If the FIFO is full and there is no simultaneous pop, the byte is dropped and overflow is set.
  - Reads return 0.
- All other addresses: reads return 0, writes are ignored.
- irq_pending sets on any edge where the current CYCLE value equals CMP.
  - The compare uses the pre-update CYCLE value, even when CYCLE is written in the same cycle.
  - If set and W1C clear occur in the same cycle, set wins.
- irq = irq_pending.
- FIFO behaviour:
  - Circular buffer with read pointer, write pointer and count; pointers wrap at FIFO_DEPTH.
  - tx_valid = count≠0; tx_data = entry at the read pointer.
  - A pop occurs on an edge where tx_valid && tx_ready.
- Simultaneous push and pop:
  - Not full: count is unchanged and both pointers advance.
  - Full: the push is accepted, count stays FIFO_DEPTH, and no overflow is raised.
- A pop when empty is ignored (tx_ready is a don't-care while tx_valid=0).

## Timing
- Asynchronous reset (reset=0) takes effect immediately.
  - CYCLE=0, CMP=0xFFFF_FFFF, irq_pending=0, overflow=0.
  - FIFO storage and pointers=0 and count=0, so tx_valid=0, tx_data=0x00, irq=0.
  - ReadData follows decode of the reset state; RAM contents are retained.
- During reset CYCLE holds 0. The first edge after release makes CYCLE=1.
- Read latency is 0 cycles: ReadData is valid in the same cycle ALUResult is presented.
  - A read of a location written in the same cycle returns the old value.
- Write latency is 1 edge: the new value is visible to reads in the following cycle.
- Push into an empty FIFO: tx_valid rises on the next cycle; there is no bypass.
- A pop advances tx_data to the next entry on the same edge that consumes the head.
- irq asserts in the cycle after the match edge and holds until cleared.
- Reset asserted mid-transfer discards FIFO contents. No partial state survives.

## Test plan
- Reset then hold: write RAM[0x10]=0xDEADBEEF, then read 0x10 → 0xDEADBEEF. Read 0x14 after writing 0x12345678 → 0x12345678. Read 0x1000 → 0.
- Counter: release reset, read CYCLE 5 cycles later → 5. Write CYCLE=0xFFFF_FFFE; next cycle reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0000_0000.
- Compare IRQ: CMP=20 → irq rises in the cycle after CYCLE==20 and STATUS bit2=1. Write STATUS=0x4 → irq=0 next cycle. Clear on the same edge as a match → irq stays 1.
- FIFO fill with tx_ready=0: push 0x41,0x42,0x43,0x44 → STATUS=0x42 (count 4, full). Push 0x45 → dropped, STATUS bit3=1. Then tx_ready=1 → tx_data 0x41,0x42,0x43,0x44 on consecutive cycles, then tx_valid=0.
- Full with simultaneous push+pop: count stays 4, no overflow, and 0x55 eventually emerges after the older bytes.
- Async reset mid-drain with 3 bytes queued → tx_valid=0, tx_data=0, irq=0 immediately. RAM word written before reset still reads back.

Source files
------------

// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side responder for the single-cycle core.
// Word-addressed RAM at the bottom of the address space, plus an MMIO page at
// 0xFFFF_FF00 holding a free-running cycle counter, a compare register that
// raises a sticky interrupt, a status/W1C register and a byte TX FIFO that
// drains to a console over valid/ready. Loads are combinational; stores and
// all state updates happen on the rising clock edge.
module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [1:0] SEL_CYCLE  = 2'd0;
  localparam logic [1:0] SEL_CMP    = 2'd1;
  localparam logic [1:0] SEL_STATUS = 2'd2;
  localparam logic [1:0] SEL_TXDATA = 2'd3;

  // Storage and architectural state
  logic [31:0]      ram [RAM_WORDS];
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [31:0]      cycle;
  logic [31:0]      cmp;
  logic             irq_pending;
  logic             overflow;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // Address decode; the byte offset bits never participate
  logic              ram_hit;
  logic              mmio_hit;
  logic [RAM_AW-1:0] ram_idx;
  logic [1:0]        sel;
  logic              unused_bits;

  assign ram_hit     = (ALUResult[31:RAM_AW+2] == '0);
  assign ram_idx     = ALUResult[RAM_AW+1:2];
  assign mmio_hit    = (ALUResult[31:4] == 28'hFFFF_FF0);
  assign sel         = ALUResult[3:2];
  assign unused_bits = ^ALUResult[1:0];

  // Per-register write strobes
  logic wr_ram, wr_cycle, wr_cmp, wr_status, wr_tx;

  assign wr_ram    = MemWrite && ram_hit;
  assign wr_cycle  = MemWrite && mmio_hit && (sel == SEL_CYCLE);
  assign wr_cmp    = MemWrite && mmio_hit && (sel == SEL_CMP);
  assign wr_status = MemWrite && mmio_hit && (sel == SEL_STATUS);
  assign wr_tx     = MemWrite && mmio_hit && (sel == SEL_TXDATA);

  // FIFO handshake: a push into a full FIFO is still accepted when the head
  // leaves on the same edge, so only a full-and-no-pop push is dropped.
  logic fifo_full, fifo_empty, pop, push, drop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign tx_valid   = !fifo_empty;
  assign tx_data    = fifo_mem[rd_ptr];
  assign pop        = tx_valid && tx_ready;
  assign push       = wr_tx && (!fifo_full || pop);
  assign drop       = wr_tx && fifo_full && !pop;

  assign irq = irq_pending;

  logic [31:0] status;
  assign status = {24'd0, 4'(count), overflow, irq_pending, fifo_full, fifo_empty};

  // Combinational load path: RAM, then MMIO page, everything else reads 0
  always_comb begin
    ReadData = 32'd0;
    if (ram_hit) begin
      ReadData = ram[ram_idx];
    end else if (mmio_hit) begin
      case (sel)
        SEL_CYCLE:  ReadData = cycle;
        SEL_CMP:    ReadData = cmp;
        SEL_STATUS: ReadData = status;
        default:    ReadData = 32'd0;
      endcase
    end
  end

  // RAM store port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram[ram_idx] <= WriteData;
    end
  end

  // Cycle counter, compare register and sticky status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle       <= 32'd0;
      cmp         <= 32'hFFFF_FFFF;
      irq_pending <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      cycle <= wr_cycle ? WriteData : cycle + 32'd1;
      if (wr_cmp) begin
        cmp <= WriteData;
      end
      // Match uses the pre-update counter; a match beats a same-edge clear
      if (cycle == cmp) begin
        irq_pending <= 1'b1;
      end else if (wr_status && WriteData[2]) begin
        irq_pending <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (wr_status && WriteData[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  // TX FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= 8'd0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= WriteData[7:0];
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed test of the data memory / MMIO responder with
// hand-computed expected values and a single checking task.
module tb_dmem_mmio;

  localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF00;
  localparam logic [31:0] A_CMP    = 32'hFFFF_FF04;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FF08;
  localparam logic [31:0] A_TX     = 32'hFFFF_FF0C;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  int checks = 0;
  int errors = 0;

  dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  // Advance one rising edge and land just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ALUResult = a;
    WriteData = d;
    MemWrite  = 1'b1;
    step();
    MemWrite  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ALUResult = a;
    #1;
    check(tag, ReadData, exp);
  endtask

  logic [7:0] drain_a [4];
  logic [7:0] drain_b [4];

  initial begin
    drain_a = '{8'h41, 8'h42, 8'h43, 8'h44};
    drain_b = '{8'h52, 8'h53, 8'h54, 8'h55};
    reset     = 1'b0;
    MemWrite  = 1'b0;
    ALUResult = 32'd0;
    WriteData = 32'd0;
    tx_ready  = 1'b0;

    // Reset state, after an edge while reset is held
    step();
    rd_chk("rst_cycle", A_CYCLE, 32'd0);
    rd_chk("rst_cmp", A_CMP, 32'hFFFF_FFFF);
    rd_chk("rst_status", A_STATUS, 32'h0000_0001);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;

    // Counter runs from 0: five edges after release reads 5
    repeat (5) step();
    rd_chk("cycle_after_5", A_CYCLE, 32'd5);

    // RAM store/load and decode holes
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_13_offset", 32'h0000_0013, 32'hDEAD_BEEF);
    wr(32'h0000_0014, 32'h1234_5678);
    rd_chk("ram_14", 32'h0000_0014, 32'h1234_5678);
    rd_chk("hole_1000", 32'h0000_1000, 32'd0);
    rd_chk("hole_1010", 32'h0000_1010, 32'd0);
    ALUResult = 32'h0000_0014;
    WriteData = 32'hCAFE_F00D;
    MemWrite  = 1'b1;
    #1;
    check("ram_same_cycle_old", ReadData, 32'h1234_5678);
    step();
    MemWrite = 1'b0;
    rd_chk("ram_14_new", 32'h0000_0014, 32'hCAFE_F00D);

    // Counter load and wrap
    wr(A_CYCLE, 32'hFFFF_FFFE);
    rd_chk("cycle_load", A_CYCLE, 32'hFFFF_FFFE);
    step();
    rd_chk("cycle_max", A_CYCLE, 32'hFFFF_FFFF);
    step();
    rd_chk("cycle_wrap", A_CYCLE, 32'd0);
    // CYCLE passed through 0xFFFF_FFFF == reset CMP, so the match fired
    check("wrap_match_irq", {31'd0, irq}, 32'd1);
    wr(A_STATUS, 32'h4);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // Compare interrupt at CYCLE == 20
    wr(A_CMP, 32'd20);
    wr(A_CYCLE, 32'd5);
    repeat (15) step();
    rd_chk("cycle_at_20", A_CYCLE, 32'd20);
    check("irq_before_match", {31'd0, irq}, 32'd0);
    step();
    check("irq_after_match", {31'd0, irq}, 32'd1);
    rd_chk("status_irq", A_STATUS, 32'h0000_0005);
    // Clear on the same edge as a match: set wins
    wr(A_CYCLE, 32'd20);
    wr(A_STATUS, 32'h4);
    check("irq_set_beats_clear", {31'd0, irq}, 32'd1);
    wr(A_STATUS, 32'h4);
    check("irq_w1c", {31'd0, irq}, 32'd0);
    rd_chk("status_clean", A_STATUS, 32'h0000_0001);
    // Match uses the counter value before a same-edge write
    wr(A_CYCLE, 32'd20);
    wr(A_CYCLE, 32'd100);
    rd_chk("cycle_loaded_100", A_CYCLE, 32'd100);
    check("irq_preupdate_match", {31'd0, irq}, 32'd1);
    wr(A_STATUS, 32'h4);
    check("irq_clear2", {31'd0, irq}, 32'd0);

    // FIFO fill with console stalled
    ALUResult = A_TX;
    WriteData = 32'h41;
    MemWrite  = 1'b1;
    #1;
    check("no_bypass_valid", {31'd0, tx_valid}, 32'd0);
    step();
    MemWrite = 1'b0;
    check("push1_valid", {31'd0, tx_valid}, 32'd1);
    check("push1_data", {24'd0, tx_data}, 32'h41);
    wr(A_TX, 32'h42);
    wr(A_TX, 32'h43);
    wr(A_TX, 32'h44);
    rd_chk("status_full", A_STATUS, 32'h0000_0042);
    wr(A_TX, 32'h45);
    rd_chk("status_overflow", A_STATUS, 32'h0000_004A);
    rd_chk("txdata_reads_0", A_TX, 32'd0);
    wr(A_STATUS, 32'h8);
    rd_chk("overflow_w1c", A_STATUS, 32'h0000_0042);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_a%0d", i), {24'd0, tx_data}, {24'd0, drain_a[i]});
      step();
    end
    check("drained_valid", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    wr(A_TX, 32'h51);
    wr(A_TX, 32'h52);
    wr(A_TX, 32'h53);
    wr(A_TX, 32'h54);
    rd_chk("status_full2", A_STATUS, 32'h0000_0042);
    tx_ready  = 1'b1;
    ALUResult = A_TX;
    WriteData = 32'h55;
    MemWrite  = 1'b1;
    #1;
    check("pushpop_head", {24'd0, tx_data}, 32'h51);
    step();
    MemWrite = 1'b0;
    rd_chk("pushpop_status", A_STATUS, 32'h0000_0042);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_b%0d", i), {24'd0, tx_data}, {24'd0, drain_b[i]});
      step();
    end
    check("drained_valid2", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Async reset in the middle of a drain with irq pending
    wr(32'h0000_0020, 32'hA5A5_A5A5);
    wr(A_TX, 32'h61);
    wr(A_TX, 32'h62);
    wr(A_TX, 32'h63);
    wr(A_CYCLE, 32'd20);
    step();
    check("irq_before_reset", {31'd0, irq}, 32'd1);
    tx_ready = 1'b1;
    step();
    check("mid_drain_data", {24'd0, tx_data}, 32'h62);
    #1;
    reset = 1'b0;
    #1;
    check("areset_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("areset_tx_data", {24'd0, tx_data}, 32'd0);
    check("areset_irq", {31'd0, irq}, 32'd0);
    rd_chk("areset_status", A_STATUS, 32'h0000_0001);
    rd_chk("areset_cycle", A_CYCLE, 32'd0);
    rd_chk("areset_cmp", A_CMP, 32'hFFFF_FFFF);
    rd_chk("ram_survives_reset", 32'h0000_0020, 32'hA5A5_A5A5);
    step();
    rd_chk("cycle_held_in_reset", A_CYCLE, 32'd0);
    check("valid_held_in_reset", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
    reset = 1'b1;
    step();
    rd_chk("cycle_first_edge", A_CYCLE, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
